// File: rtl/pfb_out_buf_if.sv
// AXI-Stream output bundle for the polyphase filter bank output buffer.
interface pfb_out_buf_if #(
    parameter int CHAN_W = 6
) ();
    logic [31:0]       tdata;
    logic [CHAN_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/pfb_out_buf.sv
// Output buffer for the PFB: realigns valid/channel with the rounded I/Q
// samples, then queues {chan, I, Q} in a first-word-fall-through FIFO.
module pfb_out_buf #(
    parameter int DEPTH   = 16,
    parameter int CHAN_W  = 6,
    parameter int RND_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              valid_in,
    input  logic [CHAN_W-1:0] chan_in,
    input  logic [15:0]       i_in,
    input  logic [15:0]       q_in,
    input  logic [CHAN_W-1:0] fft_size_m1,
    input  logic              clr_overflow,
    pfb_out_buf_if.master     m_axis,
    output logic              almost_full,
    output logic              overflow
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = CHAN_W + 32;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // Leave room for the samples still inside the rounding pipeline.
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - RND_LAT - 1);

    logic [RND_LAT-1:0] dly_valid_q;
    logic [CHAN_W-1:0]  dly_chan_q [RND_LAT];

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wptr_q, rptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_d;

    logic               push_req, push, pop, full, drop;
    logic [ENTRY_W-1:0] head;

    // ce-gated delay line tracking the rounding stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_valid_q <= '0;
            for (int i = 0; i < RND_LAT; i++) begin
                dly_chan_q[i] <= '0;
            end
        end else if (ce) begin
            dly_valid_q[0] <= valid_in;
            dly_chan_q[0]  <= chan_in;
            for (int i = 1; i < RND_LAT; i++) begin
                dly_valid_q[i] <= dly_valid_q[i-1];
                dly_chan_q[i]  <= dly_chan_q[i-1];
            end
        end
    end

    assign push_req = ce & dly_valid_q[RND_LAT-1];
    assign full     = (count_q == FULL_CNT);
    assign pop      = m_axis.tvalid & m_axis.tready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Next count and sticky overflow; a drop wins over a clear.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q  <= count_d;
            overflow <= overflow_d;
        end
    end

    // Storage is not reset; contents are only observed while tvalid=1.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {dly_chan_q[RND_LAT-1], i_in, q_in};
        end
    end

    assign head          = mem[rptr_q];
    assign m_axis.tvalid = (count_q != '0);
    assign m_axis.tdata  = head[31:0];
    assign m_axis.tuser  = head[ENTRY_W-1:32];
    assign m_axis.tlast  = (m_axis.tuser == fft_size_m1);
    assign almost_full   = (count_q >= AF_CNT);
endmodule

// File: tb/tb_pfb_out_buf.sv
// Scoreboard bench for pfb_out_buf: stimulus queues expected entries, a
// negedge monitor checks every popped word.
module tb_pfb_out_buf;
    localparam int DEPTH   = 16;
    localparam int CHAN_W  = 6;
    localparam int RND_LAT = 1;

    typedef struct {
        logic [CHAN_W-1:0] chan;
        logic [31:0]       data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ce;
    logic              valid_in;
    logic [CHAN_W-1:0] chan_in;
    logic [15:0]       i_in;
    logic [15:0]       q_in;
    logic [CHAN_W-1:0] fft_size_m1;
    logic              clr_overflow;
    logic              almost_full;
    logic              overflow;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];

    pfb_out_buf_if #(.CHAN_W(CHAN_W)) m_axis ();

    pfb_out_buf #(
        .DEPTH  (DEPTH),
        .CHAN_W (CHAN_W),
        .RND_LAT(RND_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .valid_in    (valid_in),
        .chan_in     (chan_in),
        .i_in        (i_in),
        .q_in        (q_in),
        .fft_size_m1 (fft_size_m1),
        .clr_overflow(clr_overflow),
        .m_axis      (m_axis.master),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fi(input int k);
        return 16'h1000 + 16'(k);
    endfunction

    function automatic logic [15:0] fq(input int k);
        return 16'hA5A5 ^ 16'(k * 3);
    endfunction

    // One clock: apply inputs, wait for the edge, settle 1 time unit.
    task automatic drive(input logic v, input logic [CHAN_W-1:0] ch, input logic [15:0] i,
                         input logic [15:0] q, input logic c, input logic rdy);
        valid_in      = v;
        chan_in       = ch;
        i_in          = i;
        q_in          = q;
        ce            = c;
        m_axis.tready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Back-to-back samples; I/Q trail valid by one ce cycle. Only the first
    // 'keep' samples are expected out.
    task automatic stream(input int n, input int base, input int keep, input logic rdy,
                          input logic pop_last, input logic chk_af);
        logic [15:0] pi = '0;
        logic [15:0] pq = '0;
        int          pushed;
        for (int j = 0; j <= n; j++) begin
            if (j < n && j < keep) begin
                sb.push_back('{chan: CHAN_W'(base + j), data: {fi(base + j), fq(base + j)}});
            end
            drive(j < n, CHAN_W'(base + j), pi, pq, 1'b1, (pop_last && j == n) ? 1'b1 : rdy);
            pi = fi(base + j);
            pq = fq(base + j);
            if (chk_af && j >= 1) begin
                pushed = (j > DEPTH) ? DEPTH : j;
                chk("almost_full_fill", {31'd0, almost_full}, {31'd0, pushed >= 14});
                chk("overflow_fill", {31'd0, overflow}, {31'd0, j > DEPTH});
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (m_axis.tvalid === 1'b1 && k < 200) begin
            drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
            k++;
        end
        chk("drain_timeout", {31'd0, m_axis.tvalid}, 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        m_axis.tready = 1'b0;
    endtask

    // Monitor: every handshake pops the scoreboard and compares the head word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tdata", m_axis.tdata, e.data);
                chk("tuser", {26'd0, m_axis.tuser}, {26'd0, e.chan});
                chk("tlast", {31'd0, m_axis.tlast}, {31'd0, e.chan == fft_size_m1});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        clr_overflow  = 1'b0;
        fft_size_m1   = 6'd5;
        valid_in      = 1'b0;
        chan_in       = '0;
        i_in          = '0;
        q_in          = '0;
        ce            = 1'b1;
        m_axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        chk("reset_almost_full", {31'd0, almost_full}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);

        // Latency: valid at t, I/Q at t+1, output at t+2 with no bypass.
        sb.push_back('{chan: 6'd5, data: 32'h1234ABCD});
        drive(1'b1, 6'd5, '0, '0, 1'b1, 1'b1);
        chk("lat_t1_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        drive(1'b0, '0, 16'h1234, 16'hABCD, 1'b1, 1'b1);
        chk("lat_t2_tvalid", {31'd0, m_axis.tvalid}, 32'd1);
        drain();

        // ce gaps: one sample held across 3 ce=0 cycles pushes once.
        drive(1'b1, 6'd9, '0, '0, 1'b1, 1'b0);
        sb.push_back('{chan: 6'd9, data: 32'h0BEEF00D});
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, '0, 16'h0BEE, 16'hF00D, 1'b0, 1'b0);
            chk("ce_gap_count", 32'(dut.count_q), 32'd0);
        end
        drive(1'b0, '0, 16'h0BEE, 16'hF00D, 1'b1, 1'b0);
        chk("ce_gap_count_after", 32'(dut.count_q), 32'd1);
        repeat (3) drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("ce_gap_count_hold", 32'(dut.count_q), 32'd1);
        drain();

        // Full and overflow: 17 pushes with no pops, the last one dropped.
        stream(17, 0, 16, 1'b0, 1'b0, 1'b1);
        chk("full_count", 32'(dut.count_q), 32'd16);
        drain();
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        clr_overflow = 1'b0;
        chk("overflow_cleared", {31'd0, overflow}, 32'd0);

        // Full with simultaneous push and pop on the same edge.
        stream(17, 32, 17, 1'b0, 1'b1, 1'b0);
        m_axis.tready = 1'b0;
        chk("full_pp_count", 32'(dut.count_q), 32'd16);
        chk("full_pp_overflow", {31'd0, overflow}, 32'd0);
        chk("full_pp_almost_full", {31'd0, almost_full}, 32'd1);
        drain();

        // tlast only on the last channel of a 64-channel frame.
        fft_size_m1 = 6'd63;
        stream(64, 0, 64, 1'b1, 1'b0, 1'b0);
        drain();

        // Reset mid-operation with 7 queued and one sample in flight.
        stream(7, 20, 7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 6'd40, '0, '0, 1'b1, 1'b0);
        chk("pre_reset_count", 32'(dut.count_q), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("reset_async_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("post_reset_count", 32'(dut.count_q), 32'd0);
        chk("post_reset_overflow", {31'd0, overflow}, 32'd0);
        chk("post_reset_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        stream(1, 50, 1, 1'b0, 1'b0, 1'b0);
        chk("post_reset_push", 32'(dut.count_q), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pfb_out_buf.md
PFB_OUT_BUF -- requirements
Module: pfb_out_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter CHAN_W, default 6, channel index width.
REQ-003 SHALL have parameter RND_LAT, default 1, ce-gated latency of the upstream rounding stages.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port ce  in  1  pipeline advance enable shared with the rounding stages.
REQ-007 SHALL have port valid_in  in  1  sample valid, aligned with pcin entering the rounding stages.
REQ-008 SHALL have port chan_in  in  CHAN_W  channel index aligned with valid_in.
REQ-009 SHALL have port i_in  in  16  rounded I output of the rounding stage.
REQ-010 SHALL have port q_in  in  16  rounded Q output of the rounding stage.
REQ-011 SHALL have port fft_size_m1  in  CHAN_W  last channel index in a frame; quasi-static.
REQ-012 SHALL have port clr_overflow  in  1  synchronous clear of overflow.
REQ-013 SHALL have port m_axis_tdata  out  32  {I[15:0], Q[15:0]}.
REQ-014 SHALL have port m_axis_tuser  out  CHAN_W  channel index.
REQ-015 SHALL have port m_axis_tlast  out  1  high when tuser == fft_size_m1.
REQ-016 SHALL have port m_axis_tvalid / m_axis_tready  out / in  1  AXI-Stream handshake.
REQ-017 SHALL have port almost_full  out  1  upstream throttle request.
REQ-018 SHALL have port overflow  out  1  sticky drop flag.

Function
REQ-019 SHALL delay {valid_in, chan_in} through an RND_LAT-stage shift register that advances only on edges where ce=1.
REQ-020 SHALL push {chan, i_in, q_in} into the FIFO on an edge where ce=1 and the last delay stage holds valid=1; exactly one push per sample regardless of ce gaps.
REQ-021 SHALL be first-word-fall-through: m_axis_tvalid = (count != 0), with tdata/tuser/tlast presenting the head entry.
REQ-022 SHALL pop on any edge with m_axis_tvalid=1 and m_axis_tready=1.
REQ-023 SHALL have no bypass: a push into an empty FIFO makes tvalid=1 on the following cycle.
REQ-024 SHALL handle simultaneous push and pop at any count, including full: count unchanged, both performed.
REQ-025 SHALL, on a push at count == DEPTH without a pop, drop the sample, leave pointers and count unchanged, and set overflow.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; count range 0..DEPTH.
REQ-027 SHALL drive almost_full = (count >= DEPTH - RND_LAT - 1), combinational from the count register.
REQ-028 SHALL clear overflow on clr_overflow=1, except that a drop in the same cycle leaves overflow=1.
REQ-029 SHALL compute tlast from the stored tuser against the current fft_size_m1.
REQ-030 SHALL hold tdata/tuser/tlast stable while tvalid=1 and tready=0.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously clear the delay line, pointers and count, and drive tvalid=0, almost_full=0 and overflow=0.
REQ-032 SHALL treat tdata/tuser/tlast as don't-care while tvalid=0; FIFO memory is not reset.
REQ-033 SHALL discard any sample in flight when reset is asserted mid-operation; the first push after release comes from a valid_in sampled after release.

Verification
REQ-034 SHALL verify latency: with ce=1 and tready=1, valid_in=1 and chan_in=5 at cycle t, i_in=0x1234 and q_in=0xABCD at t+1 -> tvalid=1, tdata=0x1234ABCD, tuser=5 at t+2.
REQ-035 SHALL verify ce gaps: valid_in=1 then ce=0 for 3 cycles -> exactly one push, count=1.
REQ-036 SHALL verify full and overflow: tready=0 with 17 consecutive pushes (DEPTH=16) -> count=16, almost_full=1 from count 14, overflow=1, entries 0..15 intact.
REQ-037 SHALL verify full with simultaneous push and pop: count=16, push and pop on the same edge -> count=16, no overflow, order preserved.
REQ-038 SHALL verify tlast: fft_size_m1=63 with chan 0..63 streamed -> tlast=1 only on chan 63.
REQ-039 SHALL verify reset: rst_n pulsed low with count=7 -> tvalid=0 immediately, count=0, overflow=0 after release.
